// File: rtl/addr_seq_ctrl.sv
// Read-port sequencer: issues serial addresses 0..len-1 under stall control and
// tags returning SRAM data with valid/first/last for the MAC array.
module addr_seq_ctrl #(
  parameter int ADDR_W   = 6,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              stall,
  output logic [ADDR_W-1:0] addr_serial_num,
  output logic              addr_valid,
  output logic              data_valid,
  output logic              data_first,
  output logic              data_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tag_t;

  state_t                   state_q, state_d;
  logic [ADDR_W:0]          cnt_q, cnt_d, len_r_q, len_r_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     av_q, av_d, first_q, first_d, last_q, last_d;
  tag_t [READ_LAT-1:0]      tag_q, tag_d;
  logic [ADDR_W:0]          idx, lim, idx_inc;
  logic                     can_issue, pipe_empty;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_r_d   = len_r_q;
    addr_d    = addr_q;
    av_d      = 1'b0;
    first_d   = 1'b0;
    last_d    = 1'b0;
    idx       = cnt_q;
    lim       = len_r_q;
    can_issue = 1'b0;

    // Tags shift every cycle; stall only inserts bubbles at the head.
    tag_d[0] = {av_q, first_q, last_q};
    for (int i = 1; i < READ_LAT; i++) tag_d[i] = tag_q[i-1];
    pipe_empty = 1'b1;
    for (int i = 0; i < READ_LAT; i++) if (tag_d[i].vld) pipe_empty = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && len != '0) begin
          state_d   = ISSUE;
          len_r_d   = len;
          cnt_d     = '0;
          idx       = '0;
          lim       = len;
          can_issue = 1'b1;
        end
      end
      ISSUE: can_issue = 1'b1;
      DRAIN: if (pipe_empty) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so the issue for the next cycle is decided here.
    idx_inc = idx + 1'b1;
    if (can_issue && !stall) begin
      av_d    = 1'b1;
      addr_d  = idx[ADDR_W-1:0];
      cnt_d   = idx_inc;
      first_d = (idx == '0);
      last_d  = (idx_inc == lim);
      if (last_d) state_d = DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_r_q <= '0;
      addr_q  <= '0;
      av_q    <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_r_q <= len_r_d;
      addr_q  <= addr_d;
      av_q    <= av_d;
      first_q <= first_d;
      last_q  <= last_d;
      tag_q   <= tag_d;
    end
  end

  assign addr_serial_num = addr_q;
  assign addr_valid      = av_q;
  assign data_valid      = tag_q[READ_LAT-1].vld;
  assign data_first      = tag_q[READ_LAT-1].first;
  assign data_last       = tag_q[READ_LAT-1].last;
  assign busy            = (state_q == ISSUE) || (state_q == DRAIN);
  assign done            = (state_q == DONE);
endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Directed bench for addr_seq_ctrl: runs of various lengths, stall, ignored
// starts and mid-run reset, with per-cycle expected values written out by hand.
module tb_addr_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [6:0] len = '0;
  logic [5:0] addr_serial_num;
  logic       addr_valid, data_valid, data_first, data_last, busy, done;

  int checks = 0;
  int failures = 0;

  logic       av_l [0:79];
  logic [5:0] ad_l [0:79];
  logic       dv_l [0:79];
  logic       df_l [0:79];
  logic       dl_l [0:79];
  logic       bz_l [0:79];
  logic       dn_l [0:79];

  addr_seq_ctrl #(.ADDR_W(6), .READ_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .stall(stall),
    .addr_serial_num(addr_serial_num), .addr_valid(addr_valid),
    .data_valid(data_valid), .data_first(data_first), .data_last(data_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start at one edge; afterwards the bench sits in cycle 1 of the run.
  task automatic kick(input logic [6:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  // Record outputs for cycles 1..n; stall is applied at edges s0..s1 and
  // start is pulsed (with length pl) at edges whose bit is set in smask.
  task automatic capture(input int n, input int s0, input int s1,
                         input logic [31:0] smask, input logic [6:0] pl);
    for (int c = 1; c <= n; c++) begin
      av_l[c] = addr_valid;
      ad_l[c] = addr_serial_num;
      dv_l[c] = data_valid;
      df_l[c] = data_first;
      dl_l[c] = data_last;
      bz_l[c] = busy;
      dn_l[c] = done;
      stall   = (c >= s0 && c <= s1);
      start   = (c < 32) ? smask[c] : 1'b0;
      len     = start ? pl : 7'd0;
      tick();
    end
    stall = 1'b0;
    start = 1'b0;
    len   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    len = 7'd5;
    tick();
    tick();
    rst = 1'b0;
    start = 1'b0;
    len = '0;
    checks++;
    if ({addr_serial_num, addr_valid, data_valid, data_first, data_last, busy, done} !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0",
               {addr_serial_num, addr_valid, data_valid, data_first, data_last, busy, done});
    end
    tick();
    checks++;
    if ({addr_valid, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=000", {addr_valid, busy, done});
    end
  endtask

  task automatic test_len4();
    logic [5:0] got, exp;
    kick(7'd4);
    capture(8, 0, -1, 32'h0, 7'd0);
    for (int c = 1; c <= 8; c++) begin
      got = {av_l[c], dv_l[c], df_l[c], dl_l[c], bz_l[c], dn_l[c]};
      exp = {c <= 4, c >= 3 && c <= 6, c == 3, c == 6, c <= 6, c == 7};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL len4 cyc=%0d av/dv/df/dl/busy/done got=%b exp=%b", c, got, exp);
      end
      if (c <= 4 || c == 8) begin
        checks++;
        if (ad_l[c] !== ((c == 8) ? 6'd0 : 6'(c - 1))) begin
          failures++;
          $display("FAIL len4_addr cyc=%0d got=%0d exp=%0d", c, ad_l[c], (c == 8) ? 0 : c - 1);
        end
      end
    end
  endtask

  task automatic test_len64();
    int n_av = 0, n_dv = 0, n_dn = 0, dn_cyc = 0, bad = 0, n_df = 0, n_dl = 0;
    kick(7'd64);
    capture(70, 0, -1, 32'h0, 7'd0);
    for (int c = 1; c <= 70; c++) begin
      if (av_l[c]) begin
        if (ad_l[c] !== 6'(n_av) || c != n_av + 1) bad++;
        n_av++;
      end
      if (dv_l[c]) n_dv++;
      if (df_l[c] && (c != 3 || !dv_l[c])) bad++;
      if (dl_l[c] && (c != 66 || !dv_l[c])) bad++;
      if (df_l[c]) n_df++;
      if (dl_l[c]) n_dl++;
      if (dn_l[c]) begin n_dn++; dn_cyc = c; end
    end
    checks++;
    if (n_av !== 64) begin failures++; $display("FAIL len64_issues got=%0d exp=64", n_av); end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL len64_sequence errors got=%0d exp=0", bad); end
    checks++;
    if (n_dv !== 64) begin failures++; $display("FAIL len64_data got=%0d exp=64", n_dv); end
    checks++;
    if (n_df !== 1 || n_dl !== 1) begin
      failures++; $display("FAIL len64_marks first=%0d last=%0d exp=1,1", n_df, n_dl);
    end
    checks++;
    if (n_dn !== 1 || dn_cyc !== 67) begin
      failures++; $display("FAIL len64_done count=%0d cyc=%0d exp=1,67", n_dn, dn_cyc);
    end
  endtask

  task automatic test_len1();
    logic [5:0] got, exp;
    kick(7'd1);
    capture(6, 0, -1, 32'h0, 7'd0);
    for (int c = 1; c <= 6; c++) begin
      got = {av_l[c], dv_l[c], df_l[c], dl_l[c], bz_l[c], dn_l[c]};
      exp = {c == 1, c == 3, c == 3, c == 3, c <= 3, c == 4};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL len1 cyc=%0d av/dv/df/dl/busy/done got=%b exp=%b", c, got, exp);
      end
    end
    checks++;
    if (ad_l[1] !== 6'd0) begin failures++; $display("FAIL len1_addr got=%0d exp=0", ad_l[1]); end
  endtask

  task automatic test_stall();
    logic [5:0] got, exp;
    logic [5:0] ea;
    kick(7'd8);
    capture(16, 3, 5, 32'h0, 7'd0);
    for (int c = 1; c <= 16; c++) begin
      got = {av_l[c], dv_l[c], df_l[c], dl_l[c], bz_l[c], dn_l[c]};
      exp = {(c <= 3) || (c >= 7 && c <= 11), (c >= 3 && c <= 5) || (c >= 9 && c <= 13),
             c == 3, c == 13, c <= 13, c == 14};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL stall cyc=%0d av/dv/df/dl/busy/done got=%b exp=%b", c, got, exp);
      end
      if (c <= 11) begin
        ea = (c <= 3) ? 6'(c - 1) : (c <= 6) ? 6'd2 : 6'(c - 4);
        checks++;
        if (ad_l[c] !== ea) begin
          failures++;
          $display("FAIL stall_addr cyc=%0d got=%0d exp=%0d", c, ad_l[c], ea);
        end
      end
    end
  endtask

  task automatic test_ignore();
    logic [5:0] got, exp;
    start = 1'b1;
    len = 7'd0;
    tick();
    start = 1'b0;
    capture(3, 0, -1, 32'h0, 7'd0);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if ({av_l[c], dv_l[c], bz_l[c], dn_l[c]} !== 4'b0000) begin
        failures++;
        $display("FAIL len0_ignored cyc=%0d got=%b exp=0000", c, {av_l[c], dv_l[c], bz_l[c], dn_l[c]});
      end
    end
    kick(7'd4);
    capture(11, 0, -1, 32'h84, 7'd7);
    for (int c = 1; c <= 11; c++) begin
      got = {av_l[c], dv_l[c], df_l[c], dl_l[c], bz_l[c], dn_l[c]};
      exp = {c <= 4, c >= 3 && c <= 6, c == 3, c == 6, c <= 6, c == 7};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL busy_start cyc=%0d av/dv/df/dl/busy/done got=%b exp=%b", c, got, exp);
      end
      if (c <= 4) begin
        checks++;
        if (ad_l[c] !== 6'(c - 1)) begin
          failures++;
          $display("FAIL busy_start_addr cyc=%0d got=%0d exp=%0d", c, ad_l[c], c - 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    kick(7'd8);
    capture(3, 0, -1, 32'h0, 7'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({addr_serial_num, addr_valid, data_valid, data_first, data_last, busy, done} !== 12'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%b exp=0",
               {addr_serial_num, addr_valid, data_valid, data_first, data_last, busy, done});
    end
    capture(8, 0, -1, 32'h0, 7'd0);
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if ({av_l[c], dv_l[c], bz_l[c], dn_l[c]} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_mid_quiet cyc=%0d got=%b exp=0000", c, {av_l[c], dv_l[c], bz_l[c], dn_l[c]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_len4();
    test_len64();
    test_len1();
    test_stall();
    test_ignore();
    test_reset_mid();
    test_len4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
